// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
// The CPU control FSM imports this package so op codes live in one place.
package muldiv_pkg;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PREP = 2'd1,
    RUN  = 2'd2,
    FIX  = 2'd3
  } state_t;

  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the shared datapath: radix-2 shift-add multiply or
// restoring divide step on a combined {remainder/product-high, low} accumulator.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               i_mode,
  input  logic [2*WIDTH:0]   i_acc,
  input  logic [WIDTH-1:0]   i_operand,
  output logic [2*WIDTH:0]   o_acc_next,
  output logic               o_q_bit
);

  logic [WIDTH:0]   w_addend;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH+1:0] w_rem_sh;
  logic [WIDTH+1:0] w_diff;
  logic [WIDTH:0]   w_rem_new;
  logic             w_fits;

  // Multiply: add the multiplicand into the upper half when the low bit is set.
  assign w_addend = i_acc[0] ? {1'b0, i_operand} : '0;
  assign w_sum    = {1'b0, i_acc[2*WIDTH-1:WIDTH]} + w_addend;

  // Divide: one extra bit on the trial difference keeps the borrow visible.
  assign w_rem_sh  = {i_acc[2*WIDTH:WIDTH], i_acc[WIDTH-1]};
  assign w_diff    = w_rem_sh - {2'b00, i_operand};
  assign w_fits    = ~w_diff[WIDTH+1];
  assign w_rem_new = w_fits ? w_diff[WIDTH:0] : w_rem_sh[WIDTH:0];

  always_comb begin
    if (i_mode) begin
      o_acc_next = {w_rem_new, i_acc[WIDTH-2:0], 1'b0};
      o_q_bit    = w_fits;
    end else begin
      o_acc_next = {1'b0, w_sum, i_acc[WIDTH-1:1]};
      o_q_bit    = 1'b0;
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative signed/unsigned multiply/divide with HI/LO registers, a
// start/done handshake and a divide-by-zero flag for the exception path.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int ACC_W = 2 * WIDTH + 1;

  state_t             r_state;
  state_t             w_state_next;

  logic               r_is_div;
  logic [WIDTH-1:0]   r_opa;
  logic [WIDTH-1:0]   r_opb;
  logic               r_neg_res;
  logic               r_neg_rem;
  logic [ACC_W-1:0]   r_acc;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_done;
  logic               r_dbz;

  logic               w_accept;
  logic               w_wr_ok;
  logic               w_dbz;
  logic               w_load;
  logic               w_iter;
  logic               w_finish;

  logic               w_in_signed;
  logic [WIDTH-1:0]   w_a_abs;
  logic [WIDTH-1:0]   w_b_abs;
  logic [ACC_W-1:0]   w_acc_next;
  logic               w_q_bit;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quot;
  logic [WIDTH-1:0]   w_rem;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (start) w_state_next = PREP;
      PREP:    w_state_next = w_dbz ? IDLE : RUN;
      RUN:     if (r_cnt == CNT_W'(1)) w_state_next = FIX;
      FIX:     w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    w_accept = 1'b0;
    w_wr_ok  = 1'b0;
    w_dbz    = 1'b0;
    w_load   = 1'b0;
    w_iter   = 1'b0;
    w_finish = 1'b0;
    case (r_state)
      IDLE: begin
        w_accept = start;
        w_wr_ok  = 1'b1;
      end
      PREP: begin
        w_dbz  = r_is_div && (r_opb == '0);
        w_load = ~w_dbz;
      end
      RUN:     w_iter   = 1'b1;
      FIX:     w_finish = 1'b1;
      default: ;
    endcase
  end

  // The datapath works on magnitudes; signs are reapplied in FIX.
  assign w_in_signed = op_is_signed(op);
  assign w_a_abs     = (w_in_signed && a[WIDTH-1]) ? -a : a;
  assign w_b_abs     = (w_in_signed && b[WIDTH-1]) ? -b : b;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_is_div  <= 1'b0;
      r_opa     <= '0;
      r_opb     <= '0;
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
    end else if (w_accept) begin
      r_is_div  <= op_is_div(op);
      r_opa     <= w_a_abs;
      r_opb     <= w_b_abs;
      r_neg_res <= w_in_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
      r_neg_rem <= w_in_signed && a[WIDTH-1];
    end
  end

  muldiv_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .i_mode     (r_is_div),
    .i_acc      (r_acc),
    .i_operand  (r_opb),
    .o_acc_next (w_acc_next),
    .o_q_bit    (w_q_bit)
  );

  // Multiplier and dividend both start in the low half, so one load serves both.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (w_load) begin
      r_acc <= {{(WIDTH + 1){1'b0}}, r_opa};
      r_cnt <= CNT_W'(WIDTH);
    end else if (w_iter) begin
      r_acc <= w_acc_next | ACC_W'(w_q_bit);
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign w_prod = r_neg_res ? -r_acc[2*WIDTH-1:0] : r_acc[2*WIDTH-1:0];
  assign w_quot = r_neg_res ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
  assign w_rem  = r_neg_rem ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hi   <= '0;
      r_lo   <= '0;
      r_done <= 1'b0;
      r_dbz  <= 1'b0;
    end else begin
      r_done <= w_finish | w_dbz;
      r_dbz  <= w_dbz;
      if (w_finish) begin
        if (r_is_div) begin
          r_hi <= w_rem;
          r_lo <= w_quot;
        end else begin
          r_hi <= w_prod[2*WIDTH-1:WIDTH];
          r_lo <= w_prod[WIDTH-1:0];
        end
      end else if (w_wr_ok) begin
        if (hi_we) r_hi <= wdata;
        if (lo_we) r_lo <= wdata;
      end
    end
  end

  assign busy        = (r_state != IDLE);
  assign done        = r_done;
  assign div_by_zero = r_dbz;
  assign hi          = r_hi;
  assign lo          = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed and table-driven checks of muldiv_unit at WIDTH=32 and WIDTH=8,
// plus a small random sweep at WIDTH=8 against a behavioural model.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        start32, hi_we32, lo_we32, busy32, done32, dbz32;
  logic [1:0]  op32;
  logic [31:0] a32, b32, wdata32, hi32, lo32;

  logic        start8, hi_we8, lo_we8, busy8, done8, dbz8;
  logic [1:0]  op8;
  logic [7:0]  a8, b8, wdata8, hi8, lo8;

  muldiv_unit #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .start(start32), .op(op32), .a(a32), .b(b32),
    .hi_we(hi_we32), .lo_we(lo_we32), .wdata(wdata32), .busy(busy32),
    .done(done32), .div_by_zero(dbz32), .hi(hi32), .lo(lo32)
  );

  muldiv_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .op(op8), .a(a8), .b(b8),
    .hi_we(hi_we8), .lo_we(lo_we8), .wdata(wdata8), .busy(busy8),
    .done(done8), .div_by_zero(dbz8), .hi(hi8), .lo(lo8)
  );

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t v32 [9];
  vec_t v8 [5];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run32(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       input int mid, output int lat, output int ndone,
                       output logic dbz_seen, output logic busy0, output logic busy_at_done);
    logic [31:0] hi_before;
    op32 = o; a32 = x; b32 = y; start32 = 1'b1;
    @(posedge clk); #1;
    start32 = 1'b0; hi_we32 = 1'b0; lo_we32 = 1'b0;
    a32 = $urandom; b32 = $urandom;
    busy0 = busy32; lat = -1; ndone = 0; dbz_seen = 1'b0; busy_at_done = 1'b1;
    hi_before = hi32;
    for (int n = 1; n <= 60; n++) begin
      @(posedge clk); #1;
      if (mid > 0 && n == mid + 1) begin
        start32 = 1'b0; hi_we32 = 1'b0;
        chk("hi_we_while_busy", {32'd0, hi32}, {32'd0, hi_before});
      end
      if (done32) begin
        ndone++;
        if (lat < 0) begin
          lat = n;
          busy_at_done = busy32;
        end
        if (dbz32) dbz_seen = 1'b1;
      end
      if (mid > 0 && n == mid) begin
        start32 = 1'b1; op32 = OP_MULT; a32 = 32'd2; b32 = 32'd3;
        hi_we32 = 1'b1; wdata32 = 32'hDEAD_BEEF;
      end
      if (lat >= 0 && n >= lat + 2) break;
    end
  endtask

  task automatic run8(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y,
                      output int lat, output int ndone, output logic dbz_seen);
    op8 = o; a8 = x; b8 = y; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
    lat = -1; ndone = 0; dbz_seen = 1'b0;
    for (int n = 1; n <= 30; n++) begin
      @(posedge clk); #1;
      if (done8) begin
        ndone++;
        if (lat < 0) lat = n;
        if (dbz8) dbz_seen = 1'b1;
      end
      if (lat >= 0 && n >= lat + 2) break;
    end
  endtask

  task automatic model8(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y,
                        inout logic [7:0] mh, inout logic [7:0] ml, output logic mdz);
    logic signed [7:0] tx, ty;
    int sx, sy;
    logic [31:0] rv;
    tx = x; ty = y; sx = int'(tx); sy = int'(ty); mdz = 1'b0;
    case (o)
      OP_MULT:  begin rv = 32'(sx * sy); mh = rv[15:8]; ml = rv[7:0]; end
      OP_MULTU: begin rv = 32'(int'(x) * int'(y)); mh = rv[15:8]; ml = rv[7:0]; end
      OP_DIV: begin
        if (y == 8'd0) mdz = 1'b1;
        else begin
          rv = 32'(sx / sy); ml = rv[7:0];
          rv = 32'(sx % sy); mh = rv[7:0];
        end
      end
      default: begin
        if (y == 8'd0) mdz = 1'b1;
        else begin ml = x / y; mh = x % y; end
      end
    endcase
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, nd;
    logic dz, bz0, bzd, mdz;
    logic [7:0] mh, ml;
    logic [1:0] ro;
    logic [7:0] ra, rb;

    v32[0] = '{OP_MULT,  32'hFFFF_FFFD, 32'd7,        32'hFFFF_FFFF, 32'hFFFF_FFEB};
    v32[1] = '{OP_DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD};
    v32[2] = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    v32[3] = '{OP_DIVU,  32'd100,       32'd7,        32'd2,         32'd14};
    v32[4] = '{OP_MULTU, 32'h0001_0000, 32'h0001_0000, 32'd1,        32'd0};
    v32[5] = '{OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD};
    v32[6] = '{OP_MULT,  32'hFFFF_FFFB, 32'hFFFF_FFFA, 32'd0,         32'd30};
    v32[7] = '{OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0};
    v32[8] = '{OP_DIVU,  32'hFFFF_FFFF, 32'h0001_0000, 32'h0000_FFFF, 32'h0000_FFFF};

    v8[0] = '{OP_MULTU, 32'hFF, 32'hFF, 32'hFE, 32'h01};
    v8[1] = '{OP_MULT,  32'hFD, 32'h07, 32'hFF, 32'hEB};
    v8[2] = '{OP_DIV,   32'hF9, 32'h02, 32'hFF, 32'hFD};
    v8[3] = '{OP_DIVU,  32'd200, 32'd7, 32'd4,  32'd28};
    v8[4] = '{OP_DIV,   32'h80, 32'hFF, 32'h00, 32'h80};

    start32 = 0; op32 = 0; a32 = 0; b32 = 0; hi_we32 = 0; lo_we32 = 0; wdata32 = 0;
    start8 = 0; op8 = 0; a8 = 0; b8 = 0; hi_we8 = 0; lo_we8 = 0; wdata8 = 0;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {63'd0, busy32}, 64'd0);
    chk("rst_done", {63'd0, done32}, 64'd0);
    chk("rst_dbz", {63'd0, dbz32}, 64'd0);
    chk("rst_hilo32", {hi32, lo32}, 64'd0);
    chk("rst_hilo8", {48'd0, hi8, lo8}, 64'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++) begin
      run32(v32[i].op, v32[i].a, v32[i].b, 0, lat, nd, dz, bz0, bzd);
      $display("W32 op=%0d a=%h b=%h -> hi=%h lo=%h lat=%0d", v32[i].op, v32[i].a, v32[i].b, hi32, lo32, lat);
      chk($sformatf("v32[%0d].hi", i), {32'd0, hi32}, {32'd0, v32[i].hi});
      chk($sformatf("v32[%0d].lo", i), {32'd0, lo32}, {32'd0, v32[i].lo});
      chk($sformatf("v32[%0d].lat", i), 64'(lat), 64'd34);
      chk($sformatf("v32[%0d].ndone", i), 64'(nd), 64'd1);
      chk($sformatf("v32[%0d].dbz", i), {63'd0, dz}, 64'd0);
      chk($sformatf("v32[%0d].busy0", i), {63'd0, bz0}, 64'd1);
      chk($sformatf("v32[%0d].busy_done", i), {63'd0, bzd}, 64'd0);
    end

    // MULTU with a stray start and mthi attempt issued mid-run
    run32(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 10, lat, nd, dz, bz0, bzd);
    $display("W32 MULTU mid-start -> hi=%h lo=%h lat=%0d ndone=%0d", hi32, lo32, lat, nd);
    chk("multu_mid.hi", {32'd0, hi32}, 64'h0000_0000_FFFF_FFFE);
    chk("multu_mid.lo", {32'd0, lo32}, 64'd1);
    chk("multu_mid.lat", 64'(lat), 64'd34);
    chk("multu_mid.ndone", 64'(nd), 64'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("multu_mid.idle_after", {63'd0, busy32}, 64'd0);

    // mthi / mtlo, then divide by zero leaves them untouched
    hi_we32 = 1'b1; wdata32 = 32'h1234;
    @(posedge clk); #1;
    hi_we32 = 1'b0;
    chk("mthi", {32'd0, hi32}, 64'h1234);
    lo_we32 = 1'b1; wdata32 = 32'h5678;
    @(posedge clk); #1;
    lo_we32 = 1'b0;
    chk("mtlo", {32'd0, lo32}, 64'h5678);
    run32(OP_DIVU, 32'd55, 32'd0, 0, lat, nd, dz, bz0, bzd);
    $display("W32 DIVU by zero -> hi=%h lo=%h lat=%0d dbz=%0d", hi32, lo32, lat, dz);
    chk("divu0.lat", 64'(lat), 64'd1);
    chk("divu0.dbz", {63'd0, dz}, 64'd1);
    chk("divu0.ndone", 64'(nd), 64'd1);
    chk("divu0.hilo", {hi32, lo32}, 64'h0000_1234_0000_5678);
    chk("divu0.busy_done", {63'd0, bzd}, 64'd0);

    // write together with start of a signed divide by zero
    hi_we32 = 1'b1; lo_we32 = 1'b1; wdata32 = 32'h0000_AAAA;
    run32(OP_DIV, 32'hFFFF_FFF0, 32'd0, 0, lat, nd, dz, bz0, bzd);
    $display("W32 mthi/mtlo+DIV by zero -> hi=%h lo=%h dbz=%0d", hi32, lo32, dz);
    chk("div0_wr.hilo", {hi32, lo32}, 64'h0000_AAAA_0000_AAAA);
    chk("div0_wr.dbz", {63'd0, dz}, 64'd1);

    // reset asserted in the middle of RUN
    op32 = OP_MULTU; a32 = 32'd9; b32 = 32'd9; start32 = 1'b1;
    @(posedge clk); #1;
    start32 = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("midrst.busy", {63'd0, busy32}, 64'd0);
    chk("midrst.hilo", {hi32, lo32}, 64'd0);
    nd = 0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk); #1;
      if (n == 2) rst = 1'b1;
      if (done32) nd++;
    end
    chk("midrst.no_done", 64'(nd), 64'd0);
    run32(OP_MULTU, 32'd6, 32'd7, 0, lat, nd, dz, bz0, bzd);
    $display("W32 MULTU 6x7 after reset -> hi=%h lo=%h lat=%0d", hi32, lo32, lat);
    chk("after_rst.hilo", {hi32, lo32}, 64'd42);
    chk("after_rst.lat", 64'(lat), 64'd34);

    for (int i = 0; i < 5; i++) begin
      run8(v8[i].op, v8[i].a[7:0], v8[i].b[7:0], lat, nd, dz);
      $display("W8 op=%0d a=%h b=%h -> hi=%h lo=%h lat=%0d", v8[i].op, v8[i].a[7:0], v8[i].b[7:0], hi8, lo8, lat);
      chk($sformatf("v8[%0d].hilo", i), {48'd0, hi8, lo8}, {48'd0, v8[i].hi[7:0], v8[i].lo[7:0]});
      chk($sformatf("v8[%0d].lat", i), 64'(lat), 64'd10);
      chk($sformatf("v8[%0d].ndone", i), 64'(nd), 64'd1);
    end

    mh = v8[4].hi[7:0];
    ml = v8[4].lo[7:0];
    for (int i = 0; i < 24; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = 8'($urandom);
      rb = (i % 6 == 5) ? 8'd0 : 8'($urandom);
      model8(ro, ra, rb, mh, ml, mdz);
      run8(ro, ra, rb, lat, nd, dz);
      $display("W8 rnd op=%0d a=%h b=%h -> hi=%h lo=%h dbz=%0d lat=%0d", ro, ra, rb, hi8, lo8, dz, lat);
      chk($sformatf("rnd[%0d].hilo", i), {48'd0, hi8, lo8}, {48'd0, mh, ml});
      chk($sformatf("rnd[%0d].dbz", i), {63'd0, dz}, {63'd0, mdz});
      chk($sformatf("rnd[%0d].lat", i), 64'(lat), mdz ? 64'd1 : 64'd10);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
